// File: rtl/pong_paddle_ctrl_if.sv
// Bundle of per-frame control inputs and paddle position outputs
// shared between the Pong frame logic and the paddle controller.
interface pong_paddle_ctrl_if #(
  parameter int NUM_PADDLES = 2,
  parameter int YW          = 10
);
  logic                      frame_tick;
  logic [2*NUM_PADDLES-1:0]  btn;
  logic [NUM_PADDLES-1:0]    auto_en;
  logic [YW-1:0]             ball_y;
  logic                      freeze;
  logic [NUM_PADDLES*YW-1:0] y_pos;
  logic [NUM_PADDLES-1:0]    moving;

  modport master (
    output frame_tick, btn, auto_en, ball_y, freeze,
    input  y_pos, moving
  );

  modport slave (
    input  frame_tick, btn, auto_en, ball_y, freeze,
    output y_pos, moving
  );
endinterface

// File: rtl/pong_paddle_ctrl.sv
// Per-frame vertical position controller for NUM_PADDLES Pong paddles:
// button drive with hold-to-accelerate, or ball tracking, clamped to the field.
module pong_paddle_ctrl #(
  parameter int NUM_PADDLES = 2,
  parameter int YW          = 10,
  parameter int PADDLE_H    = 64,
  parameter int TOP         = 0,
  parameter int BOTTOM      = 480,
  parameter int INIT_Y      = 208,
  parameter int DY_MIN      = 2,
  parameter int DY_MAX      = 8,
  parameter int ACCEL_TICKS = 4
) (
  input logic                 clk,
  input logic                 rst,
  pong_paddle_ctrl_if.slave   bus
);

  localparam int SW = YW + 2;
  localparam int VW = $clog2(DY_MAX + 1);
  localparam int HW = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;

  localparam logic signed [SW-1:0] TOP_S  = SW'(TOP);
  localparam logic signed [SW-1:0] MAX_S  = SW'(BOTTOM - PADDLE_H);
  localparam logic signed [SW-1:0] MIN_S  = SW'(DY_MIN);
  localparam logic signed [SW-1:0] HALF_S = SW'(PADDLE_H / 2);

  typedef enum logic [1:0] {
    DIR_IDLE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_e;

  logic [YW-1:0] y_q      [NUM_PADDLES];
  logic [YW-1:0] y_d      [NUM_PADDLES];
  dir_e          dir_q    [NUM_PADDLES];
  dir_e          dir_d    [NUM_PADDLES];
  logic [VW-1:0] vel_q    [NUM_PADDLES];
  logic [VW-1:0] vel_d    [NUM_PADDLES];
  logic [HW-1:0] hold_q   [NUM_PADDLES];
  logic [HW-1:0] hold_d   [NUM_PADDLES];
  logic          moving_q [NUM_PADDLES];
  logic          moving_d [NUM_PADDLES];

  function automatic logic signed [SW-1:0] clamp_y(input logic signed [SW-1:0] v);
    if (v < TOP_S)      return TOP_S;
    else if (v > MAX_S) return MAX_S;
    else                return v;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PADDLES; i++) begin
      if (rst) begin
        y_q[i]      <= YW'(INIT_Y);
        dir_q[i]    <= DIR_IDLE;
        vel_q[i]    <= VW'(DY_MIN);
        hold_q[i]   <= '0;
        moving_q[i] <= 1'b0;
      end else begin
        y_q[i]      <= y_d[i];
        dir_q[i]    <= dir_d[i];
        vel_q[i]    <= vel_d[i];
        hold_q[i]   <= hold_d[i];
        moving_q[i] <= moving_d[i];
      end
    end
  end

  // Next-state: freeze beats frame_tick; each paddle updated independently
  always_comb begin
    logic signed [SW-1:0] y_ext;
    logic signed [SW-1:0] tgt;
    logic signed [SW-1:0] diff;
    logic signed [SW-1:0] step;
    logic signed [SW-1:0] raw;
    logic signed [SW-1:0] nxt;
    dir_e                 req;
    for (int i = 0; i < NUM_PADDLES; i++) begin
      y_d[i]      = y_q[i];
      dir_d[i]    = dir_q[i];
      vel_d[i]    = vel_q[i];
      hold_d[i]   = hold_q[i];
      moving_d[i] = moving_q[i];
      y_ext = $signed({2'b00, y_q[i]});
      tgt   = '0;
      diff  = '0;
      step  = '0;
      raw   = '0;
      nxt   = '0;
      req   = DIR_IDLE;

      if (bus.freeze) begin
        dir_d[i]    = DIR_IDLE;
        vel_d[i]    = VW'(DY_MIN);
        hold_d[i]   = '0;
        moving_d[i] = 1'b0;
      end else if (bus.frame_tick) begin
        if (bus.auto_en[i]) begin
          tgt  = clamp_y($signed({2'b00, bus.ball_y}) - HALF_S);
          diff = tgt - y_ext;
          if (diff <= MIN_S && diff >= -MIN_S) nxt = tgt;
          else if (diff > 0)                   nxt = y_ext + MIN_S;
          else                                 nxt = y_ext - MIN_S;
          y_d[i]    = nxt[YW-1:0];
          dir_d[i]  = DIR_IDLE;
          vel_d[i]  = VW'(DY_MIN);
          hold_d[i] = '0;
        end else begin
          case (bus.btn[2*i +: 2])
            2'b01:   req = DIR_DOWN;
            2'b10:   req = DIR_UP;
            default: req = DIR_IDLE;
          endcase
          if (req == DIR_IDLE) begin
            dir_d[i]  = DIR_IDLE;
            vel_d[i]  = VW'(DY_MIN);
            hold_d[i] = '0;
          end else begin
            step = (req == dir_q[i]) ? $signed({{(SW-VW){1'b0}}, vel_q[i]}) : MIN_S;
            raw  = (req == DIR_DOWN) ? y_ext + step : y_ext - step;
            nxt  = clamp_y(raw);
            y_d[i]   = nxt[YW-1:0];
            dir_d[i] = req;
            // Hitting a wall drops the paddle back to base speed
            if (nxt != raw) begin
              vel_d[i]  = VW'(DY_MIN);
              hold_d[i] = '0;
            end else if (req == dir_q[i]) begin
              if (hold_q[i] == HW'(ACCEL_TICKS - 1)) begin
                hold_d[i] = '0;
                if (vel_q[i] < VW'(DY_MAX)) vel_d[i] = vel_q[i] + VW'(1);
              end else begin
                hold_d[i] = hold_q[i] + HW'(1);
              end
            end else begin
              vel_d[i]  = VW'(DY_MIN);
              hold_d[i] = HW'(1);
            end
          end
        end
        moving_d[i] = (y_d[i] != y_q[i]);
      end
    end
  end

  // Outputs come straight from the flops
  always_comb begin
    bus.y_pos  = '0;
    bus.moving = '0;
    for (int i = 0; i < NUM_PADDLES; i++) begin
      bus.y_pos[YW*i +: YW] = y_q[i];
      bus.moving[i]         = moving_q[i];
    end
  end

endmodule

// File: tb/tb_pong_paddle_ctrl.sv
// Self-checking bench for pong_paddle_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a model.
module tb_pong_paddle_ctrl;

  localparam int NP = 2;
  localparam int YW = 10;

  logic clk;
  logic rst;
  int   n_compared;
  int   n_mismatched;
  bit   check_en;

  int m_y   [NP];
  int m_vel [NP];
  int m_hold[NP];
  int m_dir [NP];
  bit m_mov [NP];

  pong_paddle_ctrl_if #(.NUM_PADDLES(NP), .YW(YW)) bus ();

  pong_paddle_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clampy(input int v);
    if (v < 0)   return 0;
    if (v > 416) return 416;
    return v;
  endfunction

  // Reference model: the paddle rules evaluated on plain integers each edge
  always @(posedge clk) begin
    for (int i = 0; i < NP; i++) begin
      int old, ny, req, sp, raw, t;
      old = m_y[i];
      if (rst) begin
        m_y[i] = 208; m_vel[i] = 2; m_hold[i] = 0; m_dir[i] = 0; m_mov[i] = 0;
      end else if (bus.freeze) begin
        m_vel[i] = 2; m_hold[i] = 0; m_dir[i] = 0; m_mov[i] = 0;
      end else if (bus.frame_tick) begin
        if (bus.auto_en[i]) begin
          t = clampy(int'(bus.ball_y) - 32);
          if (t - old <= 2 && old - t <= 2) ny = t;
          else ny = (t > old) ? old + 2 : old - 2;
          m_vel[i] = 2; m_hold[i] = 0; m_dir[i] = 0;
        end else begin
          req = (bus.btn[2*i +: 2] == 2'b01) ? 1 : (bus.btn[2*i +: 2] == 2'b10) ? -1 : 0;
          if (req == 0) begin
            ny = old; m_vel[i] = 2; m_hold[i] = 0; m_dir[i] = 0;
          end else begin
            sp  = (req == m_dir[i]) ? m_vel[i] : 2;
            raw = old + req * sp;
            ny  = clampy(raw);
            if (ny != raw) begin
              m_vel[i] = 2; m_hold[i] = 0;
            end else if (req == m_dir[i]) begin
              if (m_hold[i] == 3) begin
                m_hold[i] = 0;
                m_vel[i]  = (m_vel[i] + 1 > 8) ? 8 : m_vel[i] + 1;
              end else begin
                m_hold[i] = m_hold[i] + 1;
              end
            end else begin
              m_vel[i] = 2; m_hold[i] = 1;
            end
            m_dir[i] = req;
          end
        end
        m_y[i]   = ny;
        m_mov[i] = (ny != old);
      end
    end
  end

  task automatic checkOutput(input string name, input int got, input int exp);
    n_compared++;
    if (got != exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s t=%0t got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the clock edge
  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < NP; i++) begin
        checkOutput($sformatf("model_y%0d", i), int'(bus.y_pos[YW*i +: YW]), m_y[i]);
        checkOutput($sformatf("model_moving%0d", i), int'(bus.moving[i]), int'(m_mov[i]));
      end
    end
  end

  // Drive one cycle of inputs and return just after the edge that samples them
  task automatic applyStimulus(input bit r, input bit ft, input logic [3:0] b,
                               input logic [1:0] ae, input int ball, input bit fr);
    rst            = r;
    bus.frame_tick = ft;
    bus.btn        = b;
    bus.auto_en    = ae;
    bus.ball_y     = YW'(ball);
    bus.freeze     = fr;
    @(posedge clk);
    #1;
  endtask

  function automatic int ypos(input int i);
    return int'(bus.y_pos[YW*i +: YW]);
  endfunction

  int accel_exp [8] = '{210, 212, 214, 216, 219, 222, 225, 228};

  initial begin
    n_compared = 0; n_mismatched = 0; check_en = 0;
    applyStimulus(1, 0, 4'b0000, 2'b00, 0, 0);
    check_en = 1;
    checkOutput("reset_y0", ypos(0), 208);
    checkOutput("reset_y1", ypos(1), 208);
    checkOutput("reset_moving", int'(bus.moving), 0);
    repeat (3) applyStimulus(0, 1, 4'b0000, 2'b00, 0, 0);
    checkOutput("idle_y0", ypos(0), 208);
    checkOutput("idle_moving", int'(bus.moving), 0);

    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 1, 4'b0001, 2'b00, 0, 0);
      checkOutput($sformatf("accel_y0_tick%0d", k + 1), ypos(0), accel_exp[k]);
    end
    checkOutput("accel_y1", ypos(1), 208);

    applyStimulus(1, 0, 4'b0000, 2'b00, 0, 0);
    repeat (40) applyStimulus(0, 1, 4'b1000, 2'b00, 0, 0);
    checkOutput("clamp_top_y1", ypos(1), 0);
    checkOutput("clamp_top_moving1", int'(bus.moving[1]), 0);

    applyStimulus(1, 0, 4'b0000, 2'b00, 0, 0);
    repeat (5) applyStimulus(0, 1, 4'b0001, 2'b00, 0, 0);
    checkOutput("down5_y0", ypos(0), 219);
    applyStimulus(0, 1, 4'b0010, 2'b00, 0, 0);
    checkOutput("reverse_y0", ypos(0), 217);
    applyStimulus(0, 1, 4'b0011, 2'b00, 0, 0);
    checkOutput("both_btn_y0", ypos(0), 217);
    checkOutput("both_btn_moving0", int'(bus.moving[0]), 0);

    applyStimulus(1, 0, 4'b0000, 2'b00, 0, 0);
    repeat (70) applyStimulus(0, 1, 4'b0000, 2'b01, 100, 0);
    checkOutput("auto_reach_y0", ypos(0), 68);
    repeat (3) applyStimulus(0, 1, 4'b0000, 2'b01, 100, 0);
    checkOutput("auto_hold_y0", ypos(0), 68);
    checkOutput("auto_hold_moving0", int'(bus.moving[0]), 0);
    repeat (40) applyStimulus(0, 1, 4'b0000, 2'b01, 20, 0);
    checkOutput("auto_top_y0", ypos(0), 0);
    repeat (215) applyStimulus(0, 1, 4'b0000, 2'b01, 479, 0);
    checkOutput("auto_bottom_y0", ypos(0), 416);

    applyStimulus(1, 0, 4'b0000, 2'b00, 0, 0);
    applyStimulus(0, 1, 4'b0001, 2'b00, 0, 0);
    checkOutput("pre_freeze_moving0", int'(bus.moving[0]), 1);
    applyStimulus(0, 1, 4'b0001, 2'b00, 0, 1);
    checkOutput("freeze_y0", ypos(0), 210);
    checkOutput("freeze_moving0", int'(bus.moving[0]), 0);
    applyStimulus(1, 1, 4'b0001, 2'b00, 0, 1);
    checkOutput("rst_freeze_y0", ypos(0), 208);

    for (int k = 0; k < 3000; k++) begin
      bit r, ft, fr;
      logic [1:0] ae;
      r  = ($urandom_range(0, 199) == 0);
      ft = ($urandom_range(0, 1) == 1);
      fr = ($urandom_range(0, 29) == 0);
      ae = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) ae = 2'b00;
      applyStimulus(r, ft, 4'($urandom), ae, int'($urandom_range(0, 1023)), fr);
    end

    applyStimulus(0, 0, 4'b0000, 2'b00, 0, 0);
    check_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
